// File: rtl/memory_access_width_pkg.sv
// Shared memory access width type plus byte-enable and lane-shift helpers.
package memory_access_width_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memory_access_width_t;

    localparam int unsigned MaxLanes = 16;

    // Enables for an access of the given width starting at lane 'offset', clipped at the word edge.
    function automatic logic [MaxLanes-1:0] width_be(memory_access_width_t width,
                                                     int unsigned offset,
                                                     int unsigned lanes);
        logic [MaxLanes-1:0] base;
        logic [MaxLanes-1:0] lane_mask;
        lane_mask = (MaxLanes'(1) << lanes) - MaxLanes'(1);
        case (width)
            BYTE:    base = MaxLanes'(1);
            HALF:    base = MaxLanes'(3);
            default: base = lane_mask;
        endcase
        return (base << offset) & lane_mask;
    endfunction

    function automatic int unsigned lane_shift(int unsigned offset);
        return 8 * offset;
    endfunction

endpackage

// File: rtl/memory_tag_fifo.sv
// In-order tag FIFO holding bookkeeping for accepted-but-unanswered requests.
module memory_tag_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin N-channel arbiter onto one registered memory port with in-order response routing.
module memory_arbiter
    import memory_access_width_pkg::*;
#(
    parameter int unsigned N_PORTS         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                 [N_PORTS-1:0]  req_valid,
    output logic                 [N_PORTS-1:0]  req_ready,
    input  logic                 [N_PORTS-1:0]  req_we,
    input  logic          [N_PORTS*ADDR_W-1:0]  req_addr,
    input  memory_access_width_t [N_PORTS-1:0]  req_width,
    input  logic          [N_PORTS*DATA_W-1:0]  req_wdata,
    output logic                 [N_PORTS-1:0]  rsp_valid,
    output logic                 [DATA_W-1:0]   rsp_rdata,
    output logic                                mem_valid,
    output logic                                mem_we,
    output logic                 [ADDR_W-1:0]   mem_addr,
    output logic                 [DATA_W/8-1:0] mem_be,
    output logic                 [DATA_W-1:0]   mem_wdata,
    input  logic                                mem_ready,
    input  logic                                mem_rsp_valid,
    input  logic                 [DATA_W-1:0]   mem_rdata
);
    localparam int unsigned Lanes = DATA_W / 8;
    localparam int unsigned OffW  = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam int unsigned IdW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned TagW  = IdW + 2 + OffW;

    logic [IdW-1:0]       ptr_q, ptr_d, grant_id;
    logic                 grant_valid, accept;
    int unsigned          idx;

    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata, sel_bitmask;
    memory_access_width_t sel_width;
    logic [OffW-1:0]      sel_off;
    logic [MaxLanes-1:0]  sel_be_full;

    logic [TagW-1:0]      push_tag, head_tag;
    logic                 fifo_full, fifo_empty, pop;
    logic [IdW-1:0]       head_id;
    memory_access_width_t head_width;
    logic [OffW-1:0]      head_off;
    logic [MaxLanes-1:0]  head_be_full;
    logic [DATA_W-1:0]    head_bitmask;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            idx = (int'(ptr_q) + i) % N_PORTS;
            if (!grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_id    = IdW'(idx);
            end
        end
    end

    // Acceptance never depends on mem_rsp_valid, so a full FIFO blocks even on a same-cycle pop.
    assign accept    = rst_n && grant_valid && (!mem_valid || mem_ready) && !fifo_full;
    assign req_ready = accept ? (N_PORTS'(1) << grant_id) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grant_id == IdW'(N_PORTS - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_comb begin
        sel_we      = req_we[grant_id];
        sel_addr    = req_addr[grant_id*ADDR_W +: ADDR_W];
        sel_wdata   = req_wdata[grant_id*DATA_W +: DATA_W];
        sel_width   = req_width[grant_id];
        sel_off     = (Lanes > 1) ? sel_addr[OffW-1:0] : '0;
        sel_be_full = width_be(sel_width, int'(sel_off), Lanes);
        sel_bitmask = '0;
        for (int unsigned l = 0; l < Lanes; l++) begin
            sel_bitmask[8*l +: 8] = {8{sel_be_full[l]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (accept) begin
                mem_valid <= 1'b1;
                mem_we    <= sel_we;
                mem_addr  <= sel_addr & ~ADDR_W'(Lanes - 1);
                mem_be    <= sel_be_full[Lanes-1:0];
                mem_wdata <= (sel_wdata << lane_shift(int'(sel_off))) & sel_bitmask;
            end else if (mem_ready) begin
                mem_valid <= 1'b0;
            end
        end
    end

    assign push_tag = {grant_id, sel_width, sel_off};
    assign pop      = mem_rsp_valid && !fifo_empty;

    memory_tag_fifo #(
        .WIDTH (TagW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (pop),
        .wdata (push_tag),
        .rdata (head_tag),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        head_id      = head_tag[TagW-1 -: IdW];
        head_width   = memory_access_width_t'(head_tag[OffW +: 2]);
        head_off     = head_tag[OffW-1:0];
        head_be_full = width_be(head_width, 0, Lanes);
        head_bitmask = '0;
        for (int unsigned l = 0; l < Lanes; l++) begin
            head_bitmask[8*l +: 8] = {8{head_be_full[l]}};
        end
        rsp_valid = '0;
        rsp_rdata = '0;
        if (pop) begin
            rsp_valid = N_PORTS'(1) << head_id;
            rsp_rdata = (mem_rdata >> lane_shift(int'(head_off))) & head_bitmask;
        end
    end

    // Responses with nothing outstanding are dropped; flag them in simulation without stopping.
    assert property (@(posedge clk) disable iff (!rst_n) !(mem_rsp_valid && fifo_empty))
        else $warning("memory_arbiter: response received with no outstanding request");

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: arbitration order, lane mapping, backpressure and reset.
module tb_memory_arbiter;
    import memory_access_width_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                 [1:0] req_valid, req_ready, req_we;
    logic                [63:0] req_addr, req_wdata;
    memory_access_width_t [1:0] req_width;
    logic                 [1:0] rsp_valid;
    logic                [31:0] rsp_rdata;
    logic                       mem_valid, mem_we, mem_ready, mem_rsp_valid;
    logic                [31:0] mem_addr, mem_wdata, mem_rdata;
    logic                 [3:0] mem_be;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    memory_arbiter u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_width     (req_width),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .mem_valid     (mem_valid),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic we, input logic [31:0] addr,
                          input memory_access_width_t w, input logic [31:0] wdata);
        req_we[ch]              = we;
        req_addr[ch*32 +: 32]   = addr;
        req_width[ch]           = w;
        req_wdata[ch*32 +: 32]  = wdata;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b11; req_we = '0; req_addr = '0; req_wdata = '0;
        req_width = {WORD, WORD}; mem_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = '0;
        @(negedge clk); #1;
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_mem_valid", 64'(mem_valid), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_mem_addr", 64'(mem_addr), 64'h0);
        check("rst_mem_be", 64'(mem_be), 64'h0);
        @(negedge clk);
        rst_n = 1'b1; req_valid = 2'b00;
        @(negedge clk);

        // Alternating grants with both channels requesting.
        set_ch(0, 1'b0, 32'h10, WORD, 32'h0);
        set_ch(1, 1'b0, 32'h20, WORD, 32'h0);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_grant", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            if (i > 0) begin
                check("rr_mem_valid", 64'(mem_valid), 64'h1);
                check("rr_mem_addr", 64'(mem_addr), (i % 2 == 1) ? 64'h10 : 64'h20);
            end
            @(negedge clk);
        end
        req_valid = 2'b00; #1;
        check("rr_last_addr", 64'(mem_addr), 64'h20);
        @(negedge clk); #1;
        check("rr_drained", 64'(mem_valid), 64'h0);
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1; mem_rdata = 32'h1000_0000 + 32'(i); #1;
            check("rr_rsp_valid", 64'(rsp_valid), (i % 2 == 0) ? 64'h1 : 64'h2);
            check("rr_rsp_rdata", 64'(rsp_rdata), 64'h1000_0000 + 64'(i));
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0;
        @(negedge clk);

        // Byte write on ch0 at a lane-3 address.
        set_ch(0, 1'b1, 32'h103, BYTE, 32'hAB);
        req_valid = 2'b01; #1;
        check("byte_ready", 64'(req_ready), 64'h1);
        @(negedge clk); req_valid = 2'b00; #1;
        check("byte_we", 64'(mem_we), 64'h1);
        check("byte_addr", 64'(mem_addr), 64'h100);
        check("byte_be", 64'(mem_be), 64'h8);
        check("byte_wdata", 64'(mem_wdata), 64'hAB00_0000);
        mem_rsp_valid = 1'b1; mem_rdata = 32'hCD00_0000; #1;
        check("byte_rsp_valid", 64'(rsp_valid), 64'h1);
        check("byte_rsp_rdata", 64'(rsp_rdata), 64'hCD);
        @(negedge clk); mem_rsp_valid = 1'b0;

        // Half read on ch1 at the upper half.
        set_ch(1, 1'b0, 32'h202, HALF, 32'h0);
        req_valid = 2'b10; #1;
        check("half_ready", 64'(req_ready), 64'h2);
        @(negedge clk); req_valid = 2'b00; #1;
        check("half_we", 64'(mem_we), 64'h0);
        check("half_addr", 64'(mem_addr), 64'h200);
        check("half_be", 64'(mem_be), 64'hC);
        mem_rsp_valid = 1'b1; mem_rdata = 32'hBEEF_1234; #1;
        check("half_rsp_valid", 64'(rsp_valid), 64'h2);
        check("half_rsp_rdata", 64'(rsp_rdata), 64'h0000_BEEF);
        @(negedge clk); mem_rsp_valid = 1'b0;

        // Misaligned word write: enables clipped at the word edge.
        set_ch(0, 1'b1, 32'h101, WORD, 32'h1122_3344);
        req_valid = 2'b01; #1;
        check("mis_ready", 64'(req_ready), 64'h1);
        @(negedge clk); req_valid = 2'b00; #1;
        check("mis_be", 64'(mem_be), 64'hE);
        check("mis_wdata", 64'(mem_wdata), 64'h2233_4400);
        mem_rsp_valid = 1'b1; mem_rdata = 32'hAABB_CCDD; #1;
        check("mis_rsp_rdata", 64'(rsp_rdata), 64'h00AA_BBCC);
        @(negedge clk); mem_rsp_valid = 1'b0;

        // Outstanding limit: six request cycles, only four accepted.
        set_ch(0, 1'b0, 32'h40, WORD, 32'h0);
        req_valid = 2'b01;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("lim_ready", 64'(req_ready), (i < 4) ? 64'h1 : 64'h0);
            @(negedge clk);
        end
        mem_rsp_valid = 1'b1; mem_rdata = 32'h5; #1;
        check("lim_full_pop_ready", 64'(req_ready), 64'h0);
        check("lim_pop_rsp", 64'(rsp_valid), 64'h1);
        @(negedge clk); mem_rsp_valid = 1'b0; #1;
        check("lim_after_pop_ready", 64'(req_ready), 64'h1);
        @(negedge clk); req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1; #1;
            check("lim_drain_rsp", 64'(rsp_valid), 64'h1);
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0;
        @(negedge clk);

        // Downstream stall: payload held, no further acceptance.
        set_ch(1, 1'b1, 32'h300, WORD, 32'hDEAD_BEEF);
        req_valid = 2'b10; mem_ready = 1'b0; #1;
        check("stall_first_ready", 64'(req_ready), 64'h2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("stall_ready", 64'(req_ready), 64'h0);
            check("stall_mem_valid", 64'(mem_valid), 64'h1);
            check("stall_addr", 64'(mem_addr), 64'h300);
            check("stall_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        end
        req_valid = 2'b00; mem_ready = 1'b1;
        @(negedge clk); #1;
        check("stall_released", 64'(mem_valid), 64'h0);
        mem_rsp_valid = 1'b1; #1;
        check("stall_rsp", 64'(rsp_valid), 64'h2);
        @(negedge clk); mem_rsp_valid = 1'b0;

        // Reset with requests outstanding.
        set_ch(0, 1'b0, 32'h500, WORD, 32'h0);
        set_ch(1, 1'b0, 32'h600, WORD, 32'h0);
        req_valid = 2'b11;
        repeat (3) @(negedge clk);
        #1; rst_n = 1'b0; #1;
        check("mrst_mem_valid", 64'(mem_valid), 64'h0);
        check("mrst_mem_addr", 64'(mem_addr), 64'h0);
        check("mrst_req_ready", 64'(req_ready), 64'h0);
        check("mrst_rsp_valid", 64'(rsp_valid), 64'h0);
        @(negedge clk); rst_n = 1'b1; req_valid = 2'b00;
        @(negedge clk); mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
        check("mrst_stale_rsp", 64'(rsp_valid), 64'h0);
        check("mrst_stale_rdata", 64'(rsp_rdata), 64'h0);
        @(negedge clk); mem_rsp_valid = 1'b0; req_valid = 2'b11; #1;
        check("mrst_ptr_zero", 64'(req_ready), 64'h1);
        @(negedge clk); req_valid = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
